// File: rtl/mem_access_ctrl_pkg.sv
// Shared CPU definitions used by the memory-stage access controller.
package mem_access_ctrl_pkg;

  localparam int DATA_W = 16;

  // Decoder opcodes that produce a data-memory request.
  localparam logic [3:0] OP_LW = 4'b1000;
  localparam logic [3:0] OP_SW = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } mac_state_t;

endpackage

// File: rtl/mem_access_ctrl_wait_timer.sv
// Clearable, saturating wait-cycle counter; hit flags the cycle the count reaches TIMEOUT.
module wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  // Next count value; holds at TIMEOUT so the counter never wraps.
  always_comb begin
    count_next = count;
    if (count != CNT_W'(TIMEOUT)) count_next = count + 1'b1;
  end

  // hit marks the increment that lands on the limit.
  assign hit = en && (count_next == CNT_W'(TIMEOUT));

  // Counter register: cleared by reset or clr, advances only when enabled.
  always_ff @(posedge clk) begin
    if (rst || clr) count <= '0;
    else if (en)    count <= count_next;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: one outstanding LW/SW against an acked data memory,
// stalling the pipeline until the access completes, errors, or times out.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  mac_state_t state;
  logic       err_flag;
  logic       timer_clr;
  logic       timer_en;
  logic       timer_hit;

  // An ack stops the timer, so an ack in the limit cycle wins over the timeout.
  assign timer_clr = (state == ISSUE);
  assign timer_en  = (state == WAIT) && !mem_ack;

  wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .clk (clk),
    .rst (rst),
    .clr (timer_clr),
    .en  (timer_en),
    .hit (timer_hit)
  );

  // Stall is combinational so the pipeline freezes in the same cycle a request appears.
  assign stall = ((state == IDLE) && req_valid) || (state == ISSUE) || (state == WAIT);

  // Access sequencer; every output is registered and set on entry to the state that shows it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      err_flag  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      mem_en    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_we    <= req_we;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
            if (req_addr[0]) begin
              err_flag  <= 1'b1;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              state     <= DONE;
            end else begin
              mem_en <= 1'b1;
              state  <= ISSUE;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (mem_ack) begin
            if (!mem_we) rsp_rdata <= mem_rdata;
            rsp_valid <= 1'b1;
            rsp_err   <= err_flag;
            state     <= DONE;
          end else if (timer_hit) begin
            err_flag  <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          err_flag <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a latency-programmable memory responder.
module tb_mem_access_ctrl;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .stall     (stall),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Called at #1 after a rising edge with the DUT in IDLE; that cycle is cycle 0.
  // The memory acks in cycle 1+lat when give_ack is set.
  task automatic do_access(input string tag, input logic we, input logic [15:0] addr,
                           input logic [15:0] wd, input int lat, input bit give_ack,
                           input logic [15:0] rdata, input int exp_done, input bit exp_err,
                           input int exp_en_cyc, input int exp_stall,
                           input logic [15:0] exp_rdata);
    int stall_cnt = 0;
    int en_cyc    = -1;
    int done_cyc  = -1;
    bit err_seen  = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    for (int c = 0; c < 40 && done_cyc < 0; c++) begin
      mem_ack   = give_ack && (c == 1 + lat);
      mem_rdata = mem_ack ? rdata : 16'h0000;
      #1;
      if (stall) stall_cnt++;
      if (mem_en) begin
        en_cyc = c;
        chk({tag, "_mem_we"},    {31'b0, mem_we}, {31'b0, we});
        chk({tag, "_mem_addr"},  {16'b0, mem_addr}, {16'b0, addr});
        chk({tag, "_mem_wdata"}, {16'b0, mem_wdata}, {16'b0, wd});
      end
      if (rsp_valid) begin
        done_cyc = c;
        err_seen = rsp_err;
      end
      @(posedge clk);
      #1;
      if (done_cyc >= 0) req_valid = 1'b0;
    end
    mem_ack   = 1'b0;
    req_valid = 1'b0;
    chk({tag, "_done_cycle"}, done_cyc, exp_done);
    chk({tag, "_rsp_err"},    {31'b0, err_seen}, {31'b0, exp_err});
    chk({tag, "_en_cycle"},   en_cyc, exp_en_cyc);
    chk({tag, "_stall_cyc"},  stall_cnt, exp_stall);
    chk({tag, "_rsp_rdata"},  {16'b0, rsp_rdata}, {16'b0, exp_rdata});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stall"},     {31'b0, stall}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_err"},   {31'b0, rsp_err}, 32'd0);
    chk({tag, "_rsp_rdata"}, {16'b0, rsp_rdata}, 32'h0);
    chk({tag, "_mem_en"},    {31'b0, mem_en}, 32'd0);
    chk({tag, "_mem_we"},    {31'b0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"},  {16'b0, mem_addr}, 32'h0);
    chk({tag, "_mem_wdata"}, {16'b0, mem_wdata}, 32'h0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 16'h0000;
    req_wdata = 16'h0000;
    mem_rdata = 16'h0000;
    mem_ack   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outputs("rst");

    // LW, 4-cycle memory
    do_access("lw_l4", 1'b0, 16'h0040, 16'h0000, 4, 1'b1, 16'hBEEF,
              6, 1'b0, 1, 6, 16'hBEEF);
    // SW, 1-cycle memory; load data must be left alone
    do_access("sw_l1", 1'b1, 16'h0102, 16'h1234, 1, 1'b1, 16'hAAAA,
              3, 1'b0, 1, 3, 16'hBEEF);
    // Misaligned LW: no memory request
    do_access("lw_odd", 1'b0, 16'h0011, 16'h0000, 1, 1'b1, 16'h5555,
              1, 1'b1, -1, 1, 16'hBEEF);
    // No ack: timeout
    do_access("lw_tmo", 1'b0, 16'h0020, 16'h0000, 0, 1'b0, 16'h0000,
              2 + TIMEOUT, 1'b1, 1, 2 + TIMEOUT, 16'hBEEF);
    // Ack in the limit cycle wins
    do_access("lw_lim", 1'b0, 16'h0022, 16'h0000, TIMEOUT, 1'b1, 16'hC0DE,
              2 + TIMEOUT, 1'b0, 1, 2 + TIMEOUT, 16'hC0DE);

    // Reset during WAIT, then a late ack
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h0040;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("rwait_stall_in_wait", {31'b0, stall}, 32'd1);
    rst       = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 16'hDEAD;
    #1;
    chk_reset_outputs("rwait_a");
    @(posedge clk);
    #1;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    chk_reset_outputs("rwait_b");

    do_access("lw_after", 1'b0, 16'h0080, 16'h0000, 2, 1'b1, 16'h5A5A,
              4, 1'b0, 1, 4, 16'h5A5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
